// File: rtl/bp_pkg.sv
// Shared types, constants and helpers for the gshare branch predictor.
// Provides the 2-bit saturating counter type, its encodings, the
// statistics counter ceiling and the counter training function.
package bp_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;  // strong not-taken
  localparam ctr2_t CTR_WNT = 2'b01;  // weak not-taken
  localparam ctr2_t CTR_WT  = 2'b10;  // weak taken
  localparam ctr2_t CTR_STK = 2'b11;  // strong taken

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Next value of a 2-bit saturating counter trained toward 'taken'.
  function automatic ctr2_t sat_ctr_next(ctr2_t c, logic taken);
    ctr2_t n;
    if (taken) begin
      if (c == CTR_STK) n = c;
      else              n = c + 2'b01;
    end else begin
      if (c == CTR_SNT) n = c;
      else              n = c - 2'b01;
    end
    return n;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Pattern history table: 2^IDX_BITS 2-bit saturating counters.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (entries -> CTR_WNT)
//   rd_index    - combinational read address
//   rd_ctr      - counter at rd_index (old value during a same-cycle write)
//   wr_en       - train entry wr_index on the rising edge
//   wr_index    - entry to train
//   wr_taken    - training direction (1 = increment, 0 = decrement)
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_index,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_index,
  input  logic                wr_taken
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  ctr2_t table_r [ENTRIES];

  // Read port has no bypass: a write lands after the edge, so a same-cycle
  // lookup of the entry being trained still returns the old counter.
  assign rd_ctr = table_r[rd_index];

  // Counter storage: reset every entry to weak not-taken, train on wr_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= CTR_WNT;
      end
    end else if (wr_en) begin
      table_r[wr_index] <= sat_ctr_next(table_r[wr_index], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   PCF                 - fetch PC; bits [IDX_BITS+1:2] feed the hash
//   predict_taken_F     - MSB of the selected counter (combinational)
//   predict_index_F     - hashed index, carried down the pipe to execute
//   update_valid_E      - a conditional branch resolved this cycle
//   update_index_E      - index captured at fetch for that branch
//   update_taken_E      - resolved outcome
//   update_predicted_E  - prediction carried with that branch
//   ghr_o               - global history (debug)
//   branch_count        - resolved branches (saturating)
//   mispredict_count    - resolved branches that mispredicted (saturating)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         PCF,
  output logic                predict_taken_F,
  output logic [IDX_BITS-1:0] predict_index_F,
  input  logic                update_valid_E,
  input  logic [IDX_BITS-1:0] update_index_E,
  input  logic                update_taken_E,
  input  logic                update_predicted_E,
  output logic [GHR_BITS-1:0] ghr_o,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  logic [GHR_BITS-1:0] ghr_r;
  logic [GHR_BITS-1:0] ghr_next_s;
  logic [IDX_BITS-1:0] ghr_ext_s;
  logic [1:0]          rd_ctr_s;
  logic [31:0]         branch_count_r;
  logic [31:0]         mispredict_count_r;
  logic                unused_pcf_s;

  // Only the word-address bits selected by the hash matter.
  assign unused_pcf_s = ^{PCF[31:IDX_BITS+2], PCF[1:0]};

  // Zero-extend history so it folds into the low index bits.
  always_comb begin
    ghr_ext_s                = '0;
    ghr_ext_s[GHR_BITS-1:0]  = ghr_r;
  end

  // History is non-speculative: fetch always hashes with the committed GHR,
  // which is why execute trains with the index carried from fetch.
  assign predict_index_F = PCF[IDX_BITS+1:2] ^ ghr_ext_s;
  assign predict_taken_F = rd_ctr_s[1];

  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign ghr_next_s = update_taken_E;
    end else begin : g_ghrn
      assign ghr_next_s = {ghr_r[GHR_BITS-2:0], update_taken_E};
    end
  endgenerate

  sat_counter_table #(
    .IDX_BITS (IDX_BITS)
  ) u_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (predict_index_F),
    .rd_ctr   (rd_ctr_s),
    .wr_en    (update_valid_E),
    .wr_index (update_index_E),
    .wr_taken (update_taken_E)
  );

  // Global history shift register, advanced only when a branch resolves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_r <= '0;
    end else if (update_valid_E) begin
      ghr_r <= ghr_next_s;
    end
  end

  // Resolution statistics; both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else if (update_valid_E) begin
      if (branch_count_r != STAT_MAX) begin
        branch_count_r <= branch_count_r + 32'd1;
      end
      if ((update_taken_E != update_predicted_E) && (mispredict_count_r != STAT_MAX)) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end
    end
  end

  assign ghr_o            = ghr_r;
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default parameters: 64 entries,
// 4-bit history). Reference model keeps counters as integers 0..3 and
// history as an integer, derived directly from the predictor's rules.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        predict_taken_F;
  logic [5:0]  predict_index_F;
  logic        update_valid_E;
  logic [5:0]  update_index_E;
  logic        update_taken_E;
  logic        update_predicted_E;
  logic [3:0]  ghr_o;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_pht [64];
  int          m_ghr;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  exp_idx;
    logic        exp_taken;
  } vec_t;

  vec_t vecs [7];

  branch_predictor dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .PCF                (PCF),
    .predict_taken_F    (predict_taken_F),
    .predict_index_F    (predict_index_F),
    .update_valid_E     (update_valid_E),
    .update_index_E     (update_index_E),
    .update_taken_E     (update_taken_E),
    .update_predicted_E (update_predicted_E),
    .ghr_o              (ghr_o),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_br  = 32'd0;
    m_mis = 32'd0;
  endtask

  function automatic int m_index(input logic [31:0] pc);
    return ((pc >> 2) & 63) ^ m_ghr;
  endfunction

  // A PC (with random don't-care bits) that hashes to idx under current history.
  function automatic logic [31:0] pc_for(input int idx);
    logic [31:0] pc;
    pc = ($urandom & 32'hFFFF_FF03) | (32'((idx ^ m_ghr) & 63) << 2);
    return pc;
  endfunction

  task automatic m_update(input int idx, input logic t, input logic p);
    if (t) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
    else   m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
    m_ghr = ((m_ghr << 1) | int'(t)) & 15;
    if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
    if (t != p && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
  endtask

  task automatic check_state(input string tag);
    int i;
    i = m_index(PCF);
    chk({tag, "_idx"},   32'(predict_index_F), 32'(i));
    chk({tag, "_taken"}, 32'(predict_taken_F), 32'(m_pht[i] >= 2));
    chk({tag, "_ghr"},   32'(ghr_o), 32'(m_ghr));
    chk({tag, "_br"},    branch_count, m_br);
    chk({tag, "_mis"},   mispredict_count, m_mis);
  endtask

  // One clock: drive in low phase, check pre-edge view, advance model at edge.
  task automatic cycle(input string tag, input logic [31:0] pc, input logic v,
                       input logic [5:0] idx, input logic t, input logic p);
    PCF = pc; update_valid_E = v; update_index_E = idx;
    update_taken_E = t; update_predicted_E = p;
    #1;
    check_state(tag);
    @(posedge clk);
    if (v) m_update(int'(idx), t, p);
    @(negedge clk);
  endtask

  // Idle lookup of an entry, compared against a hand-derived taken bit.
  task automatic look(input string name, input int idx, input logic exp_taken);
    PCF = pc_for(idx); update_valid_E = 1'b0;
    #1;
    chk(name, 32'(predict_taken_F), 32'(exp_taken));
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0040, 6'h10, 1'b0};
    vecs[1] = '{32'h0000_0000, 6'h00, 1'b0};
    vecs[2] = '{32'h0000_00FC, 6'h3F, 1'b0};
    vecs[3] = '{32'h0000_0103, 6'h00, 1'b0};
    vecs[4] = '{32'h0000_0007, 6'h01, 1'b0};
    vecs[5] = '{32'hABCD_1234, 6'h0D, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 6'h3F, 1'b0};

    rst_n = 1'b0; PCF = 32'd0; update_valid_E = 1'b0; update_index_E = 6'd0;
    update_taken_E = 1'b0; update_predicted_E = 1'b0;
    m_reset();
    #1;
    chk("rst_idx",   32'(predict_index_F), 32'h0);
    chk("rst_taken", 32'(predict_taken_F), 32'h0);
    chk("rst_ghr",   32'(ghr_o), 32'h0);
    chk("rst_br",    branch_count, 32'h0);
    chk("rst_mis",   mispredict_count, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Hash table after reset: history is zero, every entry weak not-taken.
    for (int k = 0; k < 7; k++) begin
      PCF = vecs[k].pc;
      #1;
      chk("vec_idx",   32'(predict_index_F), 32'(vecs[k].exp_idx));
      chk("vec_taken", 32'(predict_taken_F), 32'(vecs[k].exp_taken));
      @(negedge clk);
    end

    // Two mispredicted taken updates to entry 0x10.
    cycle("upd1", 32'h0000_0040, 1'b1, 6'h10, 1'b1, 1'b0);
    PCF = 32'h0000_0040; #1;
    chk("ghr_after1", 32'(ghr_o), 32'h1);
    chk("idx_after1", 32'(predict_index_F), 32'h11);
    cycle("upd2", 32'h0000_0044, 1'b1, 6'h10, 1'b1, 1'b0);
    #1;
    chk("br_after2",  branch_count, 32'd2);
    chk("mis_after2", mispredict_count, 32'd2);
    look("e10_strong", 16, 1'b1);

    // Saturation at both ends of entry 5.
    for (int k = 0; k < 4; k++) cycle("sat_t", pc_for(5), 1'b1, 6'd5, 1'b1, 1'b1);
    look("sat_hi", 5, 1'b1);
    cycle("sat_n1", pc_for(5), 1'b1, 6'd5, 1'b0, 1'b1);
    look("nt1_still_taken", 5, 1'b1);
    cycle("sat_n2", pc_for(5), 1'b1, 6'd5, 1'b0, 1'b1);
    look("nt2_flipped", 5, 1'b0);
    for (int k = 0; k < 4; k++) cycle("sat_n", pc_for(5), 1'b1, 6'd5, 1'b0, 1'b0);
    cycle("sat_lo_t1", pc_for(5), 1'b1, 6'd5, 1'b1, 1'b0);
    look("lo_plus1", 5, 1'b0);
    cycle("sat_lo_t2", pc_for(5), 1'b1, 6'd5, 1'b1, 1'b0);
    look("lo_plus2", 5, 1'b1);

    // Same-cycle lookup and training of entry 0x20 (at weak not-taken).
    PCF = pc_for(32); update_valid_E = 1'b1; update_index_E = 6'h20;
    update_taken_E = 1'b1; update_predicted_E = 1'b0;
    #1;
    chk("same_old_taken", 32'(predict_taken_F), 32'h0);
    chk("same_old_idx",   32'(predict_index_F), 32'h20);
    @(posedge clk);
    m_update(32, 1'b1, 1'b0);
    @(negedge clk);
    update_valid_E = 1'b0;
    PCF = pc_for(32);
    #1;
    chk("same_new_taken", 32'(predict_taken_F), 32'h1);
    @(negedge clk);

    // Idle port: update inputs wiggle but nothing trains.
    for (int k = 0; k < 10; k++)
      cycle("idle", $urandom, 1'b0, 6'($urandom), k[0], ~k[0]);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++)
      cycle("rand", $urandom, ($urandom_range(0, 3) != 0), 6'($urandom),
            1'($urandom), 1'($urandom));

    // Statistics saturation from a preloaded near-max count.
    force dut.mispredict_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_count_r;
    m_mis = 32'hFFFF_FFFE;
    #1;
    chk("preload", mispredict_count, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) cycle("mis_sat", $urandom, 1'b1, 6'($urandom), 1'b1, 1'b0);
    #1;
    chk("mis_held", mispredict_count, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a training cycle.
    PCF = 32'd0; update_valid_E = 1'b1; update_index_E = 6'h10;
    update_taken_E = 1'b1; update_predicted_E = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ghr",   32'(ghr_o), 32'h0);
    chk("arst_br",    branch_count, 32'h0);
    chk("arst_mis",   mispredict_count, 32'h0);
    chk("arst_idx",   32'(predict_index_F), 32'h0);
    chk("arst_taken", 32'(predict_taken_F), 32'h0);
    PCF = 32'h0000_0040;
    #1;
    chk("arst_e10", 32'(predict_taken_F), 32'h0);
    @(posedge clk);
    @(negedge clk);
    m_reset();
    update_valid_E = 1'b0;
    rst_n = 1'b1;
    #1;
    check_state("post_rst");
    @(negedge clk);
    cycle("post_rst2", 32'h0000_0040, 1'b1, 6'h10, 1'b1, 1'b1);
    #1;
    check_state("post_rst3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
